pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, flushable pipeline stage register with a valid/ready handshake. It is the generic successor to the fixed ID/EX latch and is instantiated between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field that becomes all-zero (NOP) whenever the stage holds a bubble, and a data field. An optional second "skid" entry registers the upstream ready path, so back-pressure does not form a combinational chain through the pipeline.

## Interface
Parameters:
- DATA_W, default 160: data payload width (pc, rs1/rs2 data, imm, inst = 5×32).
- CTRL_W, default 15: control payload width (`pipe_pkg::id_ex_ctrl_t`).
- SKID_EN, default 1: 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational ready.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous kill of all held entries (branch taken / exception).
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  stage can accept an entry.
- in_ctrl_i  in  CTRL_W  upstream control bits.
- in_data_i  in  DATA_W  upstream data.
- out_valid_o  out  1  downstream entry valid.
- out_ready_i  in  1  downstream accepts.
- out_ctrl_o  out  CTRL_W  control bits; forced to 0 when out_valid_o = 0.
- out_data_o  out  DATA_W  data; undefined-but-stable when out_valid_o = 0.
- occ_o  out  2  number of held entries (0..2).

## Operation
- Transfer rules:
  - Upstream transfer when in_valid_i & in_ready_o at a rising edge.
  - Downstream transfer when out_valid_o & out_ready_i at a rising edge.
- Storage: main entry (drives the outputs) and skid entry (SKID_EN = 1 only).
- States (`pipe_pkg::stage_state_e`): ST_EMPTY, ST_ONE (main full), ST_TWO (main + skid full).
  - ST_EMPTY + upstream transfer → main ← in; next state ST_ONE.
  - ST_ONE, upstream and downstream transfer → main ← in; stays ST_ONE.
  - ST_ONE, downstream transfer only → ST_EMPTY.
  - ST_ONE, upstream transfer only → skid ← in; next state ST_TWO.
  - ST_TWO, downstream transfer → main ← skid; next state ST_ONE.
  - ST_TWO, otherwise → hold.
  - No upstream transfer is possible in ST_TWO (in_ready_o = 0).
- in_ready_o:
  - SKID_EN = 1: registered, equal to (state != ST_TWO).
  - SKID_EN = 0: equal to !out_valid_o | out_ready_i; ST_TWO is unreachable.
- flush_i has priority over everything. At the edge it is sampled:
  - both entries are invalidated; next state is ST_EMPTY;
  - any upstream transfer in the same cycle is discarded;
  - a downstream transfer in the same cycle still counts, and downstream owns it.
- out_ctrl_o = main_ctrl gated by out_valid_o, so a bubble always presents zero control (RegWEn = 0, st_en = 0, PCSel = 0).
- Data registers are not cleared on flush; only the valid bits are.
- occ_o = 0 / 1 / 2 for ST_EMPTY / ST_ONE / ST_TWO.

## Timing
- Reset (async assert, sync-safe release): state ST_EMPTY, out_valid_o = 0, out_ctrl_o = 0, out_data_o = 0, occ_o = 0, in_ready_o = 1.
- Reset asserted mid-operation: all held entries are lost immediately, without waiting for a clock edge.
- Latency: an entry accepted at edge N is visible on the outputs after edge N (one cycle) when the stage was empty, or when it had one entry that drained at the same edge.
- Throughput: one entry per cycle sustained while out_ready_i = 1.
- Back-pressure (SKID_EN = 1): in_ready_o falls one cycle after out_ready_i falls. That one-cycle window is absorbed by the skid entry.
- After a flush edge: out_valid_o = 0 and in_ready_o = 1 in the following cycle.
- All outputs are register-driven, except out_ctrl_o gating (one AND per bit) and in_ready_o when SKID_EN = 0.

## Structure
- `pipe_pkg` holds:
  - `stage_state_e`;
  - `id_ex_ctrl_t` packed struct: PCSel, RegWEn, WBSel[1:0], st_en, SB, SH, ASel, BSel, BrUn, ALUSel[3:0];
  - localparams for the per-stage CTRL_W/DATA_W defaults.
- Single module, no sub-module. The skid entry is a generate-if on SKID_EN inside pipe_stage_reg.
- Stage-specific wrappers pack and unpack structs into in_ctrl_i/in_data_i.

## Test plan
- Reset: hold rst_ni = 0 with in_valid_i = 1 and in_ctrl_i = 15'h7FFF. Required: out_valid_o = 0, out_ctrl_o = 0, occ_o = 0, in_ready_o = 1; after release, the first accepted entry appears one cycle later.
- Streaming: out_ready_i = 1, push data 1..8 on consecutive cycles. Required: the outputs show 1..8 on consecutive cycles, each one cycle after input, with no bubbles.
- Skid (SKID_EN = 1):
  - With out_valid_o = 1 and data A in main, drop out_ready_i for 3 cycles while pushing A, B, C. Required: B is captured in skid, occ_o = 2, in_ready_o = 0 from the next cycle, and C is held upstream.
  - Re-assert out_ready_i. Required: A, B, C are delivered in order with no loss or duplicate.
- Flush in ST_TWO with a simultaneous upstream push of D. Required: the next cycle shows out_valid_o = 0, out_ctrl_o = 0, occ_o = 0, and D never appears.
- SKID_EN = 0 variant: with out_ready_i = 0 and out_valid_o = 1, check in_ready_o = 0 in the same cycle. Raise out_ready_i with in_valid_i = 1: one entry is delivered and a new one accepted in the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the core pipeline stage registers.
//   stage_state_e : occupancy state of a pipe_stage_reg
//   id_ex_ctrl_t  : ID/EX control word carried in in_ctrl_i/out_ctrl_o
//   PIPE_*_W      : default payload widths for pipe_stage_reg
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W = 160;  // pc, rs1, rs2, imm, inst
   localparam int unsigned PIPE_CTRL_W = 15;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   // rsvd pads the control word out to PIPE_CTRL_W bits
   typedef struct packed {
      logic       rsvd;
      logic       pc_sel;
      logic       reg_wen;
      logic [1:0] wb_sel;
      logic       st_en;
      logic       sb;
      logic       sh;
      logic       a_sel;
      logic       b_sel;
      logic       br_un;
      logic [3:0] alu_sel;
   } id_ex_ctrl_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Flushable pipeline stage register with valid/ready handshake and optional
// skid entry that registers the upstream ready path.
//   clk_i, rst_ni          : clock, async active-low reset
//   flush_i                : kill all held entries at the next edge
//   in_valid_i/in_ready_o  : upstream handshake, in_ctrl_i/in_data_i payload
//   out_valid_o/out_ready_i: downstream handshake, out_ctrl_o/out_data_o payload
//   occ_o                  : held entries (0..2)
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W  = PIPE_DATA_W,
   parameter int unsigned CTRL_W  = PIPE_CTRL_W,
   parameter bit          SKID_EN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occ_o
);

   stage_state_e      state_q;
   logic              valid_q;
   logic              rdy_q;
   logic [CTRL_W-1:0] main_ctrl_q;
   logic [DATA_W-1:0] main_data_q;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              up_xfer;
   logic              dn_xfer;
   logic              skid_load;

   // Without a skid entry, ready must look through to the downstream stage.
   assign in_ready_o = SKID_EN ? rdy_q : (!valid_q | out_ready_i);
   assign up_xfer    = in_valid_i & in_ready_o;
   assign dn_xfer    = valid_q & out_ready_i;
   // Only reachable with SKID_EN: in ST_ONE an up-only transfer needs rdy_q.
   assign skid_load  = !flush_i && (state_q == ST_ONE) && up_xfer && !dn_xfer;

   // Main entry and occupancy state; flush drops valid bits but keeps data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_EMPTY;
         valid_q     <= 1'b0;
         rdy_q       <= 1'b1;
         main_ctrl_q <= '0;
         main_data_q <= '0;
      end else if (flush_i) begin
         state_q <= ST_EMPTY;
         valid_q <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (up_xfer) begin
                  main_ctrl_q <= in_ctrl_i;
                  main_data_q <= in_data_i;
                  valid_q     <= 1'b1;
                  state_q     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (up_xfer && dn_xfer) begin
                  main_ctrl_q <= in_ctrl_i;
                  main_data_q <= in_data_i;
               end else if (dn_xfer) begin
                  valid_q <= 1'b0;
                  state_q <= ST_EMPTY;
               end else if (skid_load) begin
                  rdy_q   <= 1'b0;
                  state_q <= ST_TWO;
               end
            end
            ST_TWO: begin
               if (dn_xfer) begin
                  main_ctrl_q <= skid_ctrl;
                  main_data_q <= skid_data;
                  rdy_q       <= 1'b1;
                  state_q     <= ST_ONE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               rdy_q   <= 1'b1;
               state_q <= ST_EMPTY;
            end
         endcase
      end
   end

   // Skid entry catches the one entry accepted while ready was still high.
   if (SKID_EN) begin : g_skid
      logic [CTRL_W-1:0] skid_ctrl_q;
      logic [DATA_W-1:0] skid_data_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
         end else if (skid_load) begin
            skid_ctrl_q <= in_ctrl_i;
            skid_data_q <= in_data_i;
         end
      end

      assign skid_ctrl = skid_ctrl_q;
      assign skid_data = skid_data_q;
   end else begin : g_no_skid
      assign skid_ctrl = '0;
      assign skid_data = '0;
   end

   // A bubble always presents an all-zero (NOP) control word.
   assign out_ctrl_o  = main_ctrl_q & {CTRL_W{valid_q}};
   assign out_valid_o = valid_q;
   assign out_data_o  = main_data_q;
   assign occ_o       = 2'(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one instance with the skid entry,
// one without.
module tb_pipe_stage_reg;

   localparam int unsigned DW = 160;
   localparam int unsigned CW = 15;
   localparam int unsigned DW0 = 32;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          flush_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [CW-1:0] in_ctrl_i;
   logic [DW-1:0] in_data_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [CW-1:0] out_ctrl_o;
   logic [DW-1:0] out_data_o;
   logic [1:0]    occ_o;

   logic           s0_flush;
   logic           s0_in_valid;
   logic           s0_in_ready;
   logic [CW-1:0]  s0_in_ctrl;
   logic [DW0-1:0] s0_in_data;
   logic           s0_out_valid;
   logic           s0_out_ready;
   logic [CW-1:0]  s0_out_ctrl;
   logic [DW0-1:0] s0_out_data;
   logic [1:0]     s0_occ;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_ctrl_i  (in_ctrl_i),
      .in_data_i  (in_data_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_ctrl_o (out_ctrl_o),
      .out_data_o (out_data_o),
      .occ_o      (occ_o)
   );

   pipe_stage_reg #(.DATA_W(DW0), .CTRL_W(CW), .SKID_EN(1'b0)) dut0 (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (s0_flush),
      .in_valid_i (s0_in_valid),
      .in_ready_o (s0_in_ready),
      .in_ctrl_i  (s0_in_ctrl),
      .in_data_i  (s0_in_data),
      .out_valid_o(s0_out_valid),
      .out_ready_i(s0_out_ready),
      .out_ctrl_o (s0_out_ctrl),
      .out_data_o (s0_out_data),
      .occ_o      (s0_occ)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic v, input logic [DW-1:0] d);
      in_valid_i = v;
      in_data_i  = d;
      in_ctrl_i  = CW'(d[CW-1:0]);
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d,
                             input logic [1:0] occ, input logic rdy);
      check({tag, " valid"}, DW'(out_valid_o), DW'(v));
      if (v) check({tag, " data"}, out_data_o, d);
      check({tag, " ctrl"}, DW'(out_ctrl_o), v ? DW'(d[CW-1:0]) : DW'(0));
      check({tag, " occ"}, DW'(occ_o), DW'(occ));
      check({tag, " ready"}, DW'(in_ready_o), DW'(rdy));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_ni       = 1'b0;
      flush_i      = 1'b0;
      out_ready_i  = 1'b0;
      in_valid_i   = 1'b1;
      in_ctrl_i    = 15'h7FFF;
      in_data_i    = DW'(160'h5);
      s0_flush     = 1'b0;
      s0_in_valid  = 1'b0;
      s0_in_ctrl   = '0;
      s0_in_data   = '0;
      s0_out_ready = 1'b0;

      // Reset holds the stage empty despite a valid input.
      tick();
      tick();
      check("rst valid", DW'(out_valid_o), DW'(0));
      check("rst ctrl", DW'(out_ctrl_o), DW'(0));
      check("rst data", out_data_o, DW'(0));
      check("rst occ", DW'(occ_o), DW'(0));
      check("rst ready", DW'(in_ready_o), DW'(1));
      rst_ni = 1'b1;
      tick();
      check("first valid", DW'(out_valid_o), DW'(1));
      check("first data", out_data_o, DW'(5));
      check("first ctrl", DW'(out_ctrl_o), DW'(15'h7FFF));
      check("first occ", DW'(occ_o), DW'(1));

      // Streaming 1..8 with downstream always ready.
      out_ready_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push(1'b1, DW'(i));
         tick();
         expect_out($sformatf("stream%0d", i), 1'b1, DW'(i), 2'd1, 1'b1);
      end

      // Skid: A in main, then back-pressure for 3 cycles while pushing B, C.
      push(1'b1, DW'(160'hA));
      tick();
      expect_out("skidA", 1'b1, DW'(160'hA), 2'd1, 1'b1);
      out_ready_i = 1'b0;
      push(1'b1, DW'(160'hB));
      tick();
      expect_out("skidB", 1'b1, DW'(160'hA), 2'd2, 1'b0);
      push(1'b1, DW'(160'hC));
      tick();
      expect_out("holdC1", 1'b1, DW'(160'hA), 2'd2, 1'b0);
      tick();
      expect_out("holdC2", 1'b1, DW'(160'hA), 2'd2, 1'b0);
      out_ready_i = 1'b1;
      tick();
      expect_out("drainB", 1'b1, DW'(160'hB), 2'd1, 1'b1);
      tick();
      expect_out("drainC", 1'b1, DW'(160'hC), 2'd1, 1'b1);

      // Refill to ST_TWO, then flush while D is offered.
      out_ready_i = 1'b0;
      push(1'b1, DW'(160'hE));
      tick();
      expect_out("two", 1'b1, DW'(160'hC), 2'd2, 1'b0);
      flush_i = 1'b1;
      push(1'b1, DW'(160'hD));
      tick();
      expect_out("flush2", 1'b0, DW'(0), 2'd0, 1'b1);
      flush_i = 1'b0;
      push(1'b0, DW'(160'hD));
      out_ready_i = 1'b1;
      tick();
      expect_out("noD", 1'b0, DW'(0), 2'd0, 1'b1);

      // Flush from empty discards a simultaneous accepted push.
      flush_i = 1'b1;
      push(1'b1, DW'(160'h3C));
      tick();
      expect_out("flush0", 1'b0, DW'(0), 2'd0, 1'b1);
      flush_i = 1'b0;
      push(1'b1, DW'(160'h77));
      tick();
      expect_out("postflush", 1'b1, DW'(160'h77), 2'd1, 1'b1);
      push(1'b0, DW'(0));

      // Single-entry variant: combinational ready follows out_ready.
      s0_in_valid  = 1'b1;
      s0_in_data   = 32'h11;
      s0_in_ctrl   = 15'h011;
      s0_out_ready = 1'b0;
      tick();
      check("s0 valid", DW'(s0_out_valid), DW'(1));
      check("s0 data1", DW'(s0_out_data), DW'(32'h11));
      s0_in_data = 32'h22;
      s0_in_ctrl = 15'h022;
      #1;
      check("s0 ready low", DW'(s0_in_ready), DW'(0));
      tick();
      check("s0 hold data", DW'(s0_out_data), DW'(32'h11));
      check("s0 hold occ", DW'(s0_occ), DW'(1));
      s0_out_ready = 1'b1;
      #1;
      check("s0 ready high", DW'(s0_in_ready), DW'(1));
      tick();
      check("s0 data2", DW'(s0_out_data), DW'(32'h22));
      check("s0 ctrl2", DW'(s0_out_ctrl), DW'(15'h022));
      check("s0 occ2", DW'(s0_occ), DW'(1));
      s0_in_valid = 1'b0;
      tick();
      check("s0 empty", DW'(s0_out_valid), DW'(0));
      check("s0 empty ctrl", DW'(s0_out_ctrl), DW'(0));

      // Mid-operation reset clears entries without a clock edge.
      out_ready_i = 1'b0;
      push(1'b1, DW'(160'h99));
      tick();
      push(1'b0, DW'(0));
      check("pre-rst valid", DW'(out_valid_o), DW'(1));
      rst_ni = 1'b0;
      #2;
      check("async rst valid", DW'(out_valid_o), DW'(0));
      check("async rst occ", DW'(occ_o), DW'(0));
      check("async rst ready", DW'(in_ready_o), DW'(1));
      check("async rst data", out_data_o, DW'(0));
      tick();
      rst_ni = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
